// File: rtl/raster_stamp_dispatch.sv
// Raster stamp collector: round-robin over slices into a stamp FIFO, then one
// stamp per active lane gathered for each core CSR request.
module raster_stamp_lane #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      dout <= '0;
        else if (clear) dout <= '0;
        else if (load)  dout <= din;
    end
endmodule

module raster_stamp_dispatch #(
    parameter int NUM_SLICES = 2,
    parameter int DEPTH      = 4,
    parameter int NUM_LANES  = 4,
    parameter int DIM_BITS   = 12,
    parameter int PID_BITS   = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_SLICES-1:0]                slice_valid,
    input  logic [NUM_SLICES-1:0][DIM_BITS-2:0]  slice_pos_x,
    input  logic [NUM_SLICES-1:0][DIM_BITS-2:0]  slice_pos_y,
    input  logic [NUM_SLICES-1:0][3:0]           slice_mask,
    input  logic [NUM_SLICES-1:0][383:0]         slice_bcoords,
    input  logic [NUM_SLICES-1:0][PID_BITS-1:0]  slice_pid,
    input  logic [NUM_SLICES-1:0]                slice_done,
    output logic [NUM_SLICES-1:0]                slice_ready,
    input  logic                                 req_valid,
    input  logic [NUM_LANES-1:0]                 req_lanes,
    output logic                                 req_ready,
    output logic                                 rsp_valid,
    output logic [NUM_LANES-1:0]                 rsp_lanes,
    output logic [NUM_LANES-1:0][31:0]           rsp_pos_mask,
    output logic [NUM_LANES-1:0][383:0]          rsp_bcoords,
    output logic [NUM_LANES-1:0][PID_BITS-1:0]   rsp_pid,
    output logic                                 rsp_done,
    input  logic                                 rsp_ready
);
    localparam int SW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [PID_BITS-1:0] pid;
        logic [383:0]        bcoords;
        logic [31:0]         pos_mask;
    } stamp_t;

    typedef enum logic [1:0] {IDLE, GATHER, RESP} state_t;

    stamp_t              mem [DEPTH];
    stamp_t              push_data;
    stamp_t              slot_q [NUM_LANES];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic [SW-1:0]       rr_ptr, grant_idx, up_idx, lo_idx;
    logic                up_any, lo_any, push, pop, start, done_set, eos;
    logic [NUM_LANES-1:0] lanes_req, pending, lane_sel;
    state_t              state, state_nxt;

    // Round robin: lowest valid slice at/after the pointer, else wrap to lowest overall.
    always_comb begin
        up_any = 1'b0;
        lo_any = 1'b0;
        up_idx = '0;
        lo_idx = '0;
        for (int j = NUM_SLICES-1; j >= 0; j--) begin
            if (slice_valid[j]) begin
                lo_any = 1'b1;
                lo_idx = SW'(j);
                if (SW'(j) >= rr_ptr) begin
                    up_any = 1'b1;
                    up_idx = SW'(j);
                end
            end
        end
        grant_idx   = up_any ? up_idx : lo_idx;
        push        = lo_any && (count != FULL);
        slice_ready = '0;
        if (push) slice_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        push_data                             = '0;
        push_data.pid                         = slice_pid[grant_idx];
        push_data.bcoords                     = slice_bcoords[grant_idx];
        push_data.pos_mask[3:0]               = slice_mask[grant_idx];
        push_data.pos_mask[4 +: DIM_BITS-1]   = slice_pos_x[grant_idx];
        push_data.pos_mask[3+DIM_BITS +: DIM_BITS-1] = slice_pos_y[grant_idx];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant_idx == SW'(NUM_SLICES-1)) ? '0 : grant_idx + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign eos     = (&slice_done) && !(|slice_valid) && (count == '0);
    assign pending = lanes_req & ~rsp_lanes;

    always_comb begin
        lane_sel = '0;
        for (int l = NUM_LANES-1; l >= 0; l--) begin
            if (pending[l]) begin
                lane_sel    = '0;
                lane_sel[l] = 1'b1;
            end
        end
    end

    // A lane completes on the same edge it is popped, so N lanes reach RESP N+1 cycles after the request.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        start     = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                start     = 1'b1;
                state_nxt = GATHER;
            end
            GATHER: begin
                if (pending == '0) begin
                    state_nxt = RESP;
                end else if (count != '0) begin
                    pop = 1'b1;
                    if ((pending & ~lane_sel) == '0) state_nxt = RESP;
                end else if (eos) begin
                    done_set  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lanes_req <= '0;
            rsp_lanes <= '0;
            rsp_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                lanes_req <= req_lanes;
                rsp_lanes <= '0;
                rsp_done  <= 1'b0;
            end else if (pop) begin
                rsp_lanes <= rsp_lanes | lane_sel;
            end
            if (done_set) rsp_done <= 1'b1;
            else if (state == RESP && rsp_ready) rsp_done <= 1'b0;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        raster_stamp_lane #(.W($bits(stamp_t))) u_lane (
            .clk   (clk),
            .reset (reset),
            .clear (start),
            .load  (pop && lane_sel[g]),
            .din   (mem[rd_ptr]),
            .dout  (slot_q[g])
        );
        assign rsp_pos_mask[g] = slot_q[g].pos_mask;
        assign rsp_bcoords[g]  = slot_q[g].bcoords;
        assign rsp_pid[g]      = slot_q[g].pid;
    end
endmodule

// File: tb/tb_raster_stamp_dispatch.sv
// Bench for raster_stamp_dispatch: directed scenarios plus random traffic, all
// checked each cycle against a queue-based model of the stamp stream.
module tb_raster_stamp_dispatch;
    localparam int NS    = 2;
    localparam int DEPTH = 4;
    localparam int NL    = 4;
    localparam int DB    = 12;
    localparam int PB    = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NS-1:0]            slice_valid, slice_done, slice_ready;
    logic [NS-1:0][DB-2:0]    slice_pos_x, slice_pos_y;
    logic [NS-1:0][3:0]       slice_mask;
    logic [NS-1:0][383:0]     slice_bcoords;
    logic [NS-1:0][PB-1:0]    slice_pid;
    logic                     req_valid, req_ready, rsp_valid, rsp_done, rsp_ready;
    logic [NL-1:0]            req_lanes, rsp_lanes;
    logic [NL-1:0][31:0]      rsp_pos_mask;
    logic [NL-1:0][383:0]     rsp_bcoords;
    logic [NL-1:0][PB-1:0]    rsp_pid;

    always #5 clk = ~clk;

    raster_stamp_dispatch #(
        .NUM_SLICES(NS), .DEPTH(DEPTH), .NUM_LANES(NL), .DIM_BITS(DB), .PID_BITS(PB)
    ) dut (
        .clk(clk), .reset(reset),
        .slice_valid(slice_valid), .slice_pos_x(slice_pos_x), .slice_pos_y(slice_pos_y),
        .slice_mask(slice_mask), .slice_bcoords(slice_bcoords), .slice_pid(slice_pid),
        .slice_done(slice_done), .slice_ready(slice_ready),
        .req_valid(req_valid), .req_lanes(req_lanes), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_lanes(rsp_lanes), .rsp_pos_mask(rsp_pos_mask),
        .rsp_bcoords(rsp_bcoords), .rsp_pid(rsp_pid), .rsp_done(rsp_done),
        .rsp_ready(rsp_ready)
    );

    typedef struct {
        logic [31:0]  pm;
        logic [383:0] bc;
        logic [PB-1:0] pid;
    } stamp_t;

    // Reference model: the buffered stamp stream and the current request's lane slots.
    stamp_t        q[$];
    stamp_t        m_slot [NL];
    int            rr, ph;          // ph: 0 waiting for request, 1 gathering, 2 responding
    logic [NL-1:0] m_lanes, m_filled;
    logic          m_done;
    int            n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rr = 0; ph = 0; m_lanes = '0; m_filled = '0; m_done = 1'b0;
        for (int l = 0; l < NL; l++) m_slot[l] = '{pm: '0, bc: '0, pid: '0};
    endtask

    task automatic set_slice(input int s, input int x, input int y, input int m, input int pid);
        logic [383:0] bc;
        for (int k = 0; k < 12; k++) bc[k*32 +: 32] = $urandom;
        slice_pos_x[s]   = x[DB-2:0];
        slice_pos_y[s]   = y[DB-2:0];
        slice_mask[s]    = m[3:0];
        slice_pid[s]     = pid[PB-1:0];
        slice_bcoords[s] = bc;
    endtask

    // One clock: check outputs mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        logic [NS-1:0] er;
        logic [NL-1:0] pend;
        int            win;
        bit            push, eos, found;
        stamp_t        st;
        @(negedge clk);
        er = '0; win = 0; push = 0;
        if (q.size() < DEPTH) begin
            for (int i = 0; i < NS; i++) begin
                int s;
                s = (rr + i) % NS;
                if (!push && ((slice_valid >> s) & 1) != 0) begin
                    push = 1; win = s; er = NS'(1) << s;
                end
            end
        end
        chk("slice_ready", 384'(slice_ready), 384'(er));
        chk("req_ready", 384'(req_ready), 384'(ph == 0));
        chk("rsp_valid", 384'(rsp_valid), 384'(ph == 2));
        chk("rsp_lanes", 384'(rsp_lanes), 384'(m_filled));
        chk("rsp_done", 384'(rsp_done), 384'(m_done));
        if (ph == 2) begin
            for (int l = 0; l < NL; l++) begin
                chk("rsp_pos_mask", 384'(rsp_pos_mask[l]), 384'(m_slot[l].pm));
                chk("rsp_pid", 384'(rsp_pid[l]), 384'(m_slot[l].pid));
                chk("rsp_bcoords", rsp_bcoords[l], m_slot[l].bc);
            end
        end
        eos = (&slice_done) && !(|slice_valid) && q.size() == 0;
        case (ph)
            0: if (req_valid) begin
                m_lanes = req_lanes; m_filled = '0; m_done = 1'b0;
                for (int l = 0; l < NL; l++) m_slot[l] = '{pm: '0, bc: '0, pid: '0};
                ph = 1;
            end
            1: begin
                pend = m_lanes & ~m_filled;
                if (pend == '0) ph = 2;
                else if (q.size() > 0) begin
                    found = 0;
                    for (int l = 0; l < NL; l++) begin
                        if (!found && pend[l]) begin
                            found = 1; m_slot[l] = q.pop_front(); m_filled[l] = 1'b1;
                        end
                    end
                    if ((m_lanes & ~m_filled) == '0) ph = 2;
                end else if (eos) begin
                    m_done = 1'b1; ph = 2;
                end
            end
            default: if (rsp_ready) begin ph = 0; m_done = 1'b0; end
        endcase
        if (push) begin
            st.pm  = 32'(slice_mask[win]) + (32'(slice_pos_x[win]) << 4) + (32'(slice_pos_y[win]) << (DB + 3));
            st.bc  = slice_bcoords[win];
            st.pid = slice_pid[win];
            q.push_back(st);
            rr = (win + 1) % NS;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        slice_valid = '0; slice_done = '0; req_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("rst_rsp_valid", 384'(rsp_valid), 384'(0));
        chk("rst_req_ready", 384'(req_ready), 384'(1));
        chk("rst_slice_ready", 384'(slice_ready), 384'(0));
        chk("rst_rsp_lanes", 384'(rsp_lanes), 384'(0));
        chk("rst_rsp_done", 384'(rsp_done), 384'(0));
        for (int l = 0; l < NL; l++) begin
            chk("rst_pos_mask", 384'(rsp_pos_mask[l]), 384'(0));
            chk("rst_pid", 384'(rsp_pid[l]), 384'(0));
            chk("rst_bcoords", rsp_bcoords[l], 384'(0));
        end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 384'(rsp_valid), 384'(1));
    endtask

    task automatic close_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int g;
        reset = 1'b0;
        slice_valid = '0; slice_done = '0; req_valid = 1'b0; req_lanes = '0; rsp_ready = 1'b0;
        for (int s = 0; s < NS; s++) set_slice(s, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // single stamp, single lane: position/mask packing and two-cycle latency
        set_slice(0, 3, 5, 4'b1011, 7);
        slice_valid = 2'b01;
        tick();
        slice_valid = '0; req_valid = 1'b1; req_lanes = 4'b0001;
        tick();
        req_valid = 1'b0;
        tick();
        chk("sc1_latency", 384'(rsp_valid), 384'(1));
        chk("sc1_lanes", 384'(rsp_lanes), 384'(4'b0001));
        chk("sc1_pos_mask", 384'(rsp_pos_mask[0]), 384'(32'h0002_803B));
        chk("sc1_pid", 384'(rsp_pid[0]), 384'(7));
        chk("sc1_done", 384'(rsp_done), 384'(0));
        close_rsp();

        // both slices streaming: grants alternate, lanes fill in grant order
        do_reset();
        slice_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            set_slice(0, $urandom, $urandom, $urandom, 'h100 + k);
            set_slice(1, $urandom, $urandom, $urandom, 'h200 + k);
            if (k == 4) begin req_valid = 1'b1; req_lanes = 4'b1111; end
            if (k == 5) req_valid = 1'b0;
            tick();
        end
        wait_rsp("sc2_timeout", 10);
        for (int l = 0; l < NL; l++)
            chk("sc2_source", 384'(rsp_pid[l][15:8]), 384'((l % 2) + 1));
        slice_valid = '0;
        close_rsp();

        // full FIFO blocks grants; two pops free exactly two slots
        do_reset();
        slice_valid = 2'b11;
        repeat (6) tick();
        chk("sc3_full", 384'(slice_ready), 384'(0));
        req_valid = 1'b1; req_lanes = 4'b0011;
        tick();
        req_valid = 1'b0;
        g = 0;
        for (int k = 0; k < 6; k++) begin
            if (slice_ready != '0) g++;
            tick();
        end
        chk("sc3_grants", 384'(g), 384'(2));
        slice_valid = '0;
        close_rsp();

        // stream ends after two stamps: partial response flagged done
        do_reset();
        set_slice(1, 9, 10, 4'b1111, 'h55);
        slice_valid = 2'b10;
        repeat (2) tick();
        slice_valid = '0; slice_done = 2'b11;
        req_valid = 1'b1; req_lanes = 4'b1111;
        tick();
        req_valid = 1'b0;
        wait_rsp("sc4_timeout", 10);
        chk("sc4_lanes", 384'(rsp_lanes), 384'(4'b0011));
        chk("sc4_done", 384'(rsp_done), 384'(1));
        chk("sc4_lane2_zero", 384'(rsp_pos_mask[2]), 384'(0));
        chk("sc4_lane3_zero", 384'(rsp_pid[3]), 384'(0));
        close_rsp();
        slice_done = '0;

        // empty lane mask, response held under backpressure
        do_reset();
        req_valid = 1'b1; req_lanes = 4'b0000;
        tick();
        req_valid = 1'b0;
        tick();
        chk("sc5_valid", 384'(rsp_valid), 384'(1));
        repeat (3) begin
            tick();
            chk("sc5_hold", 384'(rsp_valid), 384'(1));
            chk("sc5_lanes", 384'(rsp_lanes), 384'(0));
        end
        close_rsp();
        chk("sc5_release", 384'(rsp_valid), 384'(0));

        // reset during gather discards buffered stamps
        do_reset();
        slice_valid = 2'b01;
        repeat (3) tick();
        slice_valid = '0; req_valid = 1'b1; req_lanes = 4'b1111;
        tick();
        req_valid = 1'b0;
        do_reset();
        req_valid = 1'b1; req_lanes = 4'b0001;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("sc6_waits", 384'(rsp_valid), 384'(0));
        set_slice(0, 1, 2, 4'b0001, 'h77);
        slice_valid = 2'b01;
        tick();
        slice_valid = '0;
        wait_rsp("sc6_timeout", 5);
        chk("sc6_pid", 384'(rsp_pid[0]), 384'('h77));
        close_rsp();

        // random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < NS; s++) begin
                set_slice(s, $urandom, $urandom, $urandom, $urandom);
                if ($urandom_range(0, 99) < 3) slice_done[s] = ~slice_done[s];
                slice_valid[s] = ($urandom_range(0, 99) < ((&slice_done) ? 10 : 55));
            end
            req_valid = ($urandom_range(0, 2) == 0);
            req_lanes = NL'($urandom);
            rsp_ready = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
